multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Main control FSM for the multicycle MIPS datapath.
- Sequences one shared ALU through fetch, PC increment, branch-target calculation, address generation and execute; drives the memory, IR, register-file and PC enables and the ALU mux selects.
- Decodes funct for R-type instructions into the 3-bit ALU control code.
- Sits between the instruction register (op/funct) and the datapath; it is purely control and holds no datapath storage.

Parameters:
- SUPPORT_BNE, 1, when 1 opcode 000101 (bne) is decoded; when 0, bne is treated as an illegal opcode.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; forces the FSM to FETCH
- op  in  6  instruction opcode, IR[31:26]
- funct  in  6  function field, IR[5:0]
- zero  in  1  ALU zero flag, same-cycle combinational from the ALU
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- memwrite  out  1  data memory write enable
- irwrite  out  1  instruction register load enable
- regdst  out  1  write register select: 0 = rt, 1 = rd
- memtoreg  out  1  register write-data select: 0 = ALUOut, 1 = MDR
- regwrite  out  1  register file write enable
- alusrca  out  1  ALU A select: 0 = PC, 1 = register A
- alusrcb  out  2  ALU B select: 00 = B, 01 = constant 4, 10 = SignImm, 11 = SignImm<<2
- pcsrc  out  2  next-PC select: 00 = ALUResult, 01 = ALUOut, 10 = jump target
- pcen  out  1  PC load enable
- alucontrol  out  3  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt
- illegal  out  1  one-cycle pulse in DECODE when the opcode is unsupported
- state_dbg  out  4  current state encoding, for observation only

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11. Encodings 12–15 are unreachable; if entered, the next state is FETCH and all enables are 0.
- State register: async reset to FETCH. While reset=1, memwrite, irwrite, regwrite and pcen are forced to 0. All other outputs take their FETCH values.
- Outputs are Moore, decoded from the state only, except pcen, which also depends on zero.
- Any output not listed for a state is 0, and alucontrol defaults to 010.
- FETCH: iord=0, irwrite=1, alusrca=0, alusrcb=01, alucontrol=010, pcsrc=00, pcwrite=1. Next state: DECODE.
- DECODE: alusrca=0, alusrcb=11, alucontrol=010 (branch target into ALUOut). Next state by op:
  - 100011 (lw) or 101011 (sw) -> MEMADR
  - 000000 (R-type) -> EXECUTE
  - 000100 (beq), or 000101 (bne) when SUPPORT_BNE=1 -> BRANCH
  - 001000 (addi) -> ADDIEX
  - 000010 (j) -> JUMP
  - any other op -> FETCH, with illegal=1 for this cycle
- MEMADR: alusrca=1, alusrcb=10, alucontrol=010. Next: MEMRD if op=lw, else MEMWR.
- MEMRD: iord=1. Next: MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite=1. Next: FETCH.
- MEMWR: iord=1, memwrite=1. Next: FETCH.
- EXECUTE: alusrca=1, alusrcb=00, alucontrol from funct:
  - 100000 -> 010
  - 100010 -> 110
  - 100100 -> 000
  - 100101 -> 001
  - 101010 -> 111
  - any other funct -> 010
  - Next: ALUWB.
- ALUWB: regdst=1, memtoreg=0, regwrite=1. Next: FETCH.
- BRANCH: alusrca=1, alusrcb=00, alucontrol=110, pcsrc=01.
  - beq: branch=1; bne: branchne=1.
  - Next: FETCH.
- ADDIEX: alusrca=1, alusrcb=10, alucontrol=010. Next: ADDIWB.
- ADDIWB: regdst=0, memtoreg=0, regwrite=1. Next: FETCH.
- JUMP: pcsrc=10, pcwrite=1. Next: FETCH.
- pcen = pcwrite | (branch & zero) | (branchne & ~zero), gated by ~reset.
- op and funct are sampled combinationally every cycle. They must be stable from DECODE onward; the IR is written only in FETCH.
- Cycle counts per instruction: lw 5; sw, R-type and addi 4; beq, bne and j 3; illegal 2.
- Reset asserted mid-instruction: the FSM enters FETCH asynchronously, no partial writes occur after the reset edge, and the first fetch happens on the first rising clk edge after reset deasserts.

Test Plan:
- Reset: hold reset=1 for 3 clk with op=100011 -> state_dbg=0 and pcen=irwrite=regwrite=memwrite=0 throughout; first clk after release gives pcen=1, irwrite=1.
- lw (op=100011): after reset release -> state sequence 0,1,2,3,4,0; regwrite=1 only in state 4 with memtoreg=1; iord=1 in state 3.
- R-type slt (op=0, funct=101010): sequence 0,1,6,7,0; alucontrol=111 in state 6; regdst=1, regwrite=1 in state 7. Repeat with funct=100010 -> alucontrol=110.
- beq/bne: beq with zero=1 in BRANCH -> pcen=1, pcsrc=01; beq with zero=0 -> pcen=0; bne with zero=0 -> pcen=1.
- j and sw: j gives sequence 0,1,11,0 with pcsrc=10 and pcen=1 in state 11; sw gives 0,1,2,5,0 with memwrite=1 only in state 5.
- Illegal and mid-instruction reset: op=111111 -> illegal=1 for exactly one cycle in state 1, then state 0. Assert reset mid-cycle in state 4 -> state_dbg=0 immediately and regwrite=0 before the next clk edge.

Source files
------------

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_controller
// Description : Main control FSM for a multicycle MIPS datapath. Steps one
//               shared ALU through fetch/PC+4, branch-target calculation,
//               address generation and execute. Drives the memory, IR,
//               register-file and PC enables plus the datapath mux selects.
//               Decodes funct into the 3-bit ALU control code for R-type
//               instructions. Holds no datapath storage.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk         in   1  system clock, rising edge
//   reset       in   1  asynchronous active-high reset, forces FETCH
//   op          in   6  opcode, IR[31:26]
//   funct       in   6  function field, IR[5:0]
//   zero        in   1  ALU zero flag (same-cycle combinational)
//   iord        out  1  memory address select (0 PC, 1 ALUOut)
//   memwrite    out  1  data memory write enable
//   irwrite     out  1  instruction register load enable
//   regdst      out  1  write register select (0 rt, 1 rd)
//   memtoreg    out  1  write data select (0 ALUOut, 1 MDR)
//   regwrite    out  1  register file write enable
//   alusrca     out  1  ALU A select (0 PC, 1 reg A)
//   alusrcb     out  2  ALU B select (00 B, 01 4, 10 SignImm, 11 SignImm<<2)
//   pcsrc       out  2  next-PC select (00 ALUResult, 01 ALUOut, 10 jump)
//   pcen        out  1  PC load enable
//   alucontrol  out  3  ALU operation code
//   illegal     out  1  one-cycle pulse in DECODE for an unsupported opcode
//   state_dbg   out  4  current state encoding (observation only)
// ============================================================================
module multicycle_controller #(
   parameter int unsigned SUPPORT_BNE = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   output logic       iord,
   output logic       memwrite,
   output logic       irwrite,
   output logic       regdst,
   output logic       memtoreg,
   output logic       regwrite,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] pcsrc,
   output logic       pcen,
   output logic [2:0] alucontrol,
   output logic       illegal,
   output logic [3:0] state_dbg
);

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_EXECUTE = 4'd6,
      S_ALUWB   = 4'd7,
      S_BRANCH  = 4'd8,
      S_ADDIEX  = 4'd9,
      S_ADDIWB  = 4'd10,
      S_JUMP    = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] FN_ADD   = 6'b100000;
   localparam logic [5:0] FN_SUB   = 6'b100010;
   localparam logic [5:0] FN_AND   = 6'b100100;
   localparam logic [5:0] FN_OR    = 6'b100101;
   localparam logic [5:0] FN_SLT   = 6'b101010;

   localparam logic [2:0] ALU_ADD  = 3'b010;
   localparam logic [2:0] ALU_SUB  = 3'b110;
   localparam logic [2:0] ALU_AND  = 3'b000;
   localparam logic [2:0] ALU_OR   = 3'b001;
   localparam logic [2:0] ALU_SLT  = 3'b111;

   state_t state_q;
   state_t state_d;

   // Internal PC-update qualifiers combined into pcen below.
   logic pcwrite;
   logic branch;
   logic branchne;
   logic is_bne;
   logic [2:0] funct_alu;

   assign is_bne = (SUPPORT_BNE != 0) && (op == OP_BNE);

   // R-type funct decode; unknown funct codes fall back to add.
   always_comb begin
      funct_alu = ALU_ADD;
      case (funct)
         FN_ADD:  funct_alu = ALU_ADD;
         FN_SUB:  funct_alu = ALU_SUB;
         FN_AND:  funct_alu = ALU_AND;
         FN_OR:   funct_alu = ALU_OR;
         FN_SLT:  funct_alu = ALU_SLT;
         default: funct_alu = ALU_ADD;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d    = S_FETCH;
      iord       = 1'b0;
      memwrite   = 1'b0;
      irwrite    = 1'b0;
      regdst     = 1'b0;
      memtoreg   = 1'b0;
      regwrite   = 1'b0;
      alusrca    = 1'b0;
      alusrcb    = 2'b00;
      pcsrc      = 2'b00;
      alucontrol = ALU_ADD;
      illegal    = 1'b0;
      pcwrite    = 1'b0;
      branch     = 1'b0;
      branchne   = 1'b0;

      case (state_q)
         S_FETCH: begin
            // Instruction read and PC+4 share this cycle.
            irwrite    = 1'b1;
            alusrcb    = 2'b01;
            pcwrite    = 1'b1;
            state_d    = S_DECODE;
         end
         S_DECODE: begin
            // Precompute branch target into ALUOut while decoding.
            alusrcb    = 2'b11;
            if (op == OP_LW || op == OP_SW) begin
               state_d = S_MEMADR;
            end else if (op == OP_RTYPE) begin
               state_d = S_EXECUTE;
            end else if (op == OP_BEQ || is_bne) begin
               state_d = S_BRANCH;
            end else if (op == OP_ADDI) begin
               state_d = S_ADDIEX;
            end else if (op == OP_J) begin
               state_d = S_JUMP;
            end else begin
               illegal = 1'b1;
               state_d = S_FETCH;
            end
         end
         S_MEMADR: begin
            alusrca    = 1'b1;
            alusrcb    = 2'b10;
            state_d    = (op == OP_LW) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            iord       = 1'b1;
            state_d    = S_MEMWB;
         end
         S_MEMWB: begin
            memtoreg   = 1'b1;
            regwrite   = 1'b1;
            state_d    = S_FETCH;
         end
         S_MEMWR: begin
            iord       = 1'b1;
            memwrite   = 1'b1;
            state_d    = S_FETCH;
         end
         S_EXECUTE: begin
            alusrca    = 1'b1;
            alucontrol = funct_alu;
            state_d    = S_ALUWB;
         end
         S_ALUWB: begin
            regdst     = 1'b1;
            regwrite   = 1'b1;
            state_d    = S_FETCH;
         end
         S_BRANCH: begin
            alusrca    = 1'b1;
            alucontrol = ALU_SUB;
            pcsrc      = 2'b01;
            branch     = (op == OP_BEQ);
            branchne   = is_bne;
            state_d    = S_FETCH;
         end
         S_ADDIEX: begin
            alusrca    = 1'b1;
            alusrcb    = 2'b10;
            state_d    = S_ADDIWB;
         end
         S_ADDIWB: begin
            regwrite   = 1'b1;
            state_d    = S_FETCH;
         end
         S_JUMP: begin
            pcsrc      = 2'b10;
            pcwrite    = 1'b1;
            state_d    = S_FETCH;
         end
         default: begin
            // Unused encodings recover to FETCH with every enable low.
            state_d    = S_FETCH;
         end
      endcase

      pcen = pcwrite | (branch & zero) | (branchne & ~zero);

      // Reset suppresses every write strobe, including the cycle in which
      // it arrives asynchronously mid-instruction.
      if (reset) begin
         memwrite = 1'b0;
         irwrite  = 1'b0;
         regwrite = 1'b0;
         pcen     = 1'b0;
      end
   end

   assign state_dbg = state_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_controller
// Description : Scoreboard bench for multicycle_controller. A driver issues
//               whole instructions (directed, then random), pushing the
//               expected per-cycle control word into a queue; a monitor pops
//               and compares on every falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_controller;

   logic       clk   = 1'b0;
   logic       reset = 1'b1;
   logic [5:0] op    = 6'b100011;
   logic [5:0] funct = 6'b000000;
   logic       zero  = 1'b0;

   logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
   logic [1:0] alusrcb, pcsrc;
   logic       pcen, illegal;
   logic [2:0] alucontrol;
   logic [3:0] state_dbg;

   multicycle_controller #(.SUPPORT_BNE(1)) dut (
      .clk        (clk),
      .reset      (reset),
      .op         (op),
      .funct      (funct),
      .zero       (zero),
      .iord       (iord),
      .memwrite   (memwrite),
      .irwrite    (irwrite),
      .regdst     (regdst),
      .memtoreg   (memtoreg),
      .regwrite   (regwrite),
      .alusrca    (alusrca),
      .alusrcb    (alusrcb),
      .pcsrc      (pcsrc),
      .pcen       (pcen),
      .alucontrol (alucontrol),
      .illegal    (illegal),
      .state_dbg  (state_dbg)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] st;
      logic       iord;
      logic       memwrite;
      logic       irwrite;
      logic       regdst;
      logic       memtoreg;
      logic       regwrite;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [1:0] pcsrc;
      logic       pcen;
      logic [2:0] aluc;
      logic       illegal;
   } out_t;

   localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
   localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101;
   localparam logic [5:0] ADDI = 6'b001000, JMP = 6'b000010;

   out_t exp_q[$];
   int   num_checks = 0;
   int   num_errors = 0;
   int   zero_mode  = -1;   // -1 random, 0/1 forced

   function automatic bit is_legal(logic [5:0] o);
      return (o == LW) || (o == SW) || (o == RT) || (o == BEQ) ||
             (o == BNE) || (o == ADDI) || (o == JMP);
   endfunction

   // Sequence of visited states for one instruction, -1 terminated.
   function automatic int path_state(logic [5:0] o, int idx);
      int seq[6];
      if      (o == LW)   seq = '{0, 1, 2, 3, 4, -1};
      else if (o == SW)   seq = '{0, 1, 2, 5, -1, -1};
      else if (o == RT)   seq = '{0, 1, 6, 7, -1, -1};
      else if (o == BEQ || o == BNE) seq = '{0, 1, 8, -1, -1, -1};
      else if (o == ADDI) seq = '{0, 1, 9, 10, -1, -1};
      else if (o == JMP)  seq = '{0, 1, 11, -1, -1, -1};
      else                seq = '{0, 1, -1, -1, -1, -1};
      return seq[idx];
   endfunction

   function automatic int path_len(logic [5:0] o);
      int n = 0;
      while (n < 6 && path_state(o, n) >= 0) n++;
      return n;
   endfunction

   function automatic logic [2:0] alu_of(logic [5:0] f);
      if (f == 6'b100000) return 3'b010;
      if (f == 6'b100010) return 3'b110;
      if (f == 6'b100100) return 3'b000;
      if (f == 6'b100101) return 3'b001;
      if (f == 6'b101010) return 3'b111;
      return 3'b010;
   endfunction

   // Expected control word for a state, from the per-state output table.
   function automatic out_t model(int s, logic [5:0] o, logic [5:0] f,
                                  logic z, logic r);
      out_t e;
      e      = '0;
      e.st   = 4'(s);
      e.aluc = 3'b010;
      if (s == 0) begin e.irwrite = 1; e.alusrcb = 2'b01; e.pcen = 1; end
      if (s == 1) begin e.alusrcb = 2'b11; e.illegal = !is_legal(o); end
      if (s == 2 || s == 9) begin e.alusrca = 1; e.alusrcb = 2'b10; end
      if (s == 3) e.iord = 1;
      if (s == 4) begin e.memtoreg = 1; e.regwrite = 1; end
      if (s == 5) begin e.iord = 1; e.memwrite = 1; end
      if (s == 6) begin e.alusrca = 1; e.aluc = alu_of(f); end
      if (s == 7) begin e.regdst = 1; e.regwrite = 1; end
      if (s == 8) begin
         e.alusrca = 1; e.aluc = 3'b110; e.pcsrc = 2'b01;
         e.pcen = (o == BEQ) ? z : !z;
      end
      if (s == 10) e.regwrite = 1;
      if (s == 11) begin e.pcsrc = 2'b10; e.pcen = 1; end
      if (r) begin e.memwrite = 0; e.irwrite = 0; e.regwrite = 0; e.pcen = 0; end
      return e;
   endfunction

   // One clock cycle: drive after the rising edge, queue the expectation.
   task automatic step(int s, logic [5:0] o, logic [5:0] f, logic r);
      @(posedge clk);
      #1;
      reset = r;
      op    = o;
      funct = f;
      zero  = (zero_mode < 0) ? 1'($urandom) : zero_mode[0];
      exp_q.push_back(model(s, o, f, zero, r));
   endtask

   // Issue a full instruction; abort_idx >= 0 asserts reset at that cycle.
   task automatic run_instr(logic [5:0] o, logic [5:0] f, int abort_idx);
      int n = path_len(o);
      for (int i = 0; i < n; i++) begin
         if (i == abort_idx) begin
            step(0, o, f, 1'b1);
            step(0, o, f, 1'b1);
            return;
         end
         step(path_state(o, i), o, f, 1'b0);
      end
   endtask

   // Monitor: compare the DUT control word against the oldest expectation.
   always @(negedge clk) begin
      out_t e, a;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a.st = state_dbg;   a.iord = iord;         a.memwrite = memwrite;
         a.irwrite = irwrite; a.regdst = regdst;    a.memtoreg = memtoreg;
         a.regwrite = regwrite; a.alusrca = alusrca; a.alusrcb = alusrcb;
         a.pcsrc = pcsrc;     a.pcen = pcen;         a.aluc = alucontrol;
         a.illegal = illegal;
         num_checks++;
         if (a !== e) begin
            num_errors++;
            $display("FAIL ctrl_word t=%0t state exp=%0d: actual=%h required=%h",
                     $time, e.st, a, e);
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [5:0] o, f;
      int n, ab;
      logic [5:0] legal_ops[7];
      logic [5:0] fns[5];
      legal_ops = '{LW, SW, RT, BEQ, BNE, ADDI, JMP};
      fns       = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

      // Reset held three cycles with a lw opcode present.
      for (int i = 0; i < 3; i++) step(0, LW, 6'd0, 1'b1);

      // Directed instructions.
      run_instr(LW,  6'd0, -1);
      run_instr(RT,  6'b101010, -1);
      run_instr(RT,  6'b100010, -1);
      zero_mode = 1; run_instr(BEQ, 6'd0, -1);
      zero_mode = 0; run_instr(BEQ, 6'd0, -1);
      zero_mode = 0; run_instr(BNE, 6'd0, -1);
      zero_mode = 1; run_instr(BNE, 6'd0, -1);
      zero_mode = -1;
      run_instr(JMP, 6'd0, -1);
      run_instr(SW,  6'd0, -1);
      run_instr(ADDI, 6'd0, -1);
      run_instr(6'b111111, 6'd0, -1);
      run_instr(RT,  6'b111111, -1);
      // Reset arriving in MEMWB of a lw.
      run_instr(LW,  6'd0, 4);
      run_instr(LW,  6'd0, -1);

      // Random instruction stream.
      for (int k = 0; k < 300; k++) begin
         if ($urandom_range(0, 5) == 0) begin
            do o = 6'($urandom); while (is_legal(o));
         end else begin
            o = legal_ops[$urandom_range(0, 6)];
         end
         f = ($urandom_range(0, 1) == 0) ? fns[$urandom_range(0, 4)]
                                          : 6'($urandom);
         n  = path_len(o);
         ab = ($urandom_range(0, 15) == 0) ? int'($urandom_range(1, n - 1)) : -1;
         run_instr(o, f, ab);
      end

      @(negedge clk);
      #1;
      num_checks++;
      if (exp_q.size() != 0) begin
         num_errors++;
         $display("FAIL drain: pending=%0d required=0", exp_q.size());
      end

      $display("Result: errors=%0d of %0d checks", num_errors, num_checks);
      $finish;
   end

endmodule
`default_nettype wire
